// File: rtl/twiddle_cmult_pkg.sv
// Shared helpers for the twiddle complex multiplier.
// - Complex word pack/unpack bit positions, as functions of component width.
// - Rounding constant used before the Q-format shift.
// - Signed saturation to an arbitrary width, evaluated on a 64-bit carrier.
package twiddle_cmult_pkg;

    // Real part occupies the upper half of a packed complex word.
    function automatic int unsigned re_hi(int unsigned w);
        return 2 * w - 1;
    endfunction

    function automatic int unsigned re_lo(int unsigned w);
        return w;
    endfunction

    function automatic int unsigned im_hi(int unsigned w);
        return w - 1;
    endfunction

    function automatic int unsigned im_lo(int unsigned w);
        return 0 * w;
    endfunction

    // Half an output LSB for a Q(nbits-1) coefficient; no rounding bit exists below Q1.
    function automatic int round_const(int unsigned nbits);
        return (nbits >= 2) ? (1 << (nbits - 2)) : 0;
    endfunction

    // Clamp x to the signed range of a w-bit integer.
    function automatic logic signed [63:0] sat_signed(logic signed [63:0] x, int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/twiddle_cmult_sat_round.sv
// Round, arithmetic-shift and saturate one product component.
// Ports:
//   value      signed IW-bit sum of products
//   rounded_c  OW-bit saturated result (combinational)
//   clipped_c  high when saturation changed the value (combinational)
module twiddle_cmult_sat_round
    import twiddle_cmult_pkg::*;
#(
    parameter int unsigned IW  = 11,
    parameter int unsigned OW  = 8,
    parameter int unsigned SH  = 1,
    parameter int          RND = 1
) (
    input  logic signed [IW-1:0] value,
    output logic        [OW-1:0] rounded_c,
    output logic                 clipped_c
);

    logic signed [IW:0] biased;
    logic signed [IW:0] shifted;
    logic signed [63:0] wide;
    logic signed [63:0] limited;

    // One guard bit keeps the rounding add from wrapping.
    always_comb begin
        biased    = (IW + 1)'(value) + (IW + 1)'(RND);
        shifted   = biased >>> SH;
        wide      = 64'(shifted);
        limited   = sat_signed(wide, OW);
        rounded_c = OW'(limited);
        clipped_c = (limited != wide);
    end

endmodule

// File: rtl/twiddle_cmult.sv
// Pipelined complex multiplier for twiddle-coefficient rotation.
// Each valid sample is multiplied by the coefficient presented with it,
// rounded/saturated back to DBITS and tagged with its frame position.
// Latency is 3 cycles from the accepting edge to out_valid.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   sample/coefficient valid this cycle
//   in_data    {re, im} signed data, DBITS each
//   coeff_in   {re, im} signed Q(NBITS-1) twiddle, NBITS each
//   out_valid  result valid
//   out_data   {re, im} rounded, saturated product
//   out_idx    frame position 0..N-1
//   out_last   high with out_idx == N-1
//   out_sat    either component clipped
module twiddle_cmult
    import twiddle_cmult_pkg::*;
#(
    parameter int unsigned NBITS = 2,
    parameter int unsigned DBITS = 8,
    parameter int unsigned N     = 8,
    parameter int unsigned IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [2*DBITS-1:0]   in_data,
    input  logic [2*NBITS-1:0]   coeff_in,
    output logic                 out_valid,
    output logic [2*DBITS-1:0]   out_data,
    output logic [IDXW-1:0]      out_idx,
    output logic                 out_last,
    output logic                 out_sat
);

    localparam int unsigned PW   = DBITS + NBITS;
    localparam int unsigned SW   = PW + 1;
    localparam int unsigned SH   = NBITS - 1;
    localparam int          RND  = round_const(NBITS);
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    // Stage 1: captured operands and frame position
    logic                    s1_valid;
    logic signed [DBITS-1:0] s1_ar;
    logic signed [DBITS-1:0] s1_ai;
    logic signed [NBITS-1:0] s1_br;
    logic signed [NBITS-1:0] s1_bi;
    logic [IDXW-1:0]         s1_idx;
    logic [IDXW-1:0]         frame_cnt;

    // Stage 2: partial products
    logic                    s2_valid;
    logic signed [PW-1:0]    s2_rr;
    logic signed [PW-1:0]    s2_ii;
    logic signed [PW-1:0]    s2_ri;
    logic signed [PW-1:0]    s2_ir;
    logic [IDXW-1:0]         s2_idx;

    // Stage 3: full-precision real/imag sums
    logic                    s3_valid;
    logic signed [SW-1:0]    s3_re;
    logic signed [SW-1:0]    s3_im;
    logic [IDXW-1:0]         s3_idx;

    logic [DBITS-1:0]        re_rounded_c;
    logic [DBITS-1:0]        im_rounded_c;
    logic                    re_clipped_c;
    logic                    im_clipped_c;

    // Control path: stage valids, frame counter and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            frame_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid;
            if (in_valid) begin
                frame_cnt <= (frame_cnt == LAST) ? '0 : frame_cnt + 1'b1;
            end
            // Outputs hold through bubbles.
            if (s3_valid) begin
                out_data <= {re_rounded_c, im_rounded_c};
                out_idx  <= s3_idx;
                out_last <= (s3_idx == LAST);
                out_sat  <= re_clipped_c | im_clipped_c;
            end
        end
    end

    // Datapath: loaded only alongside a valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_ar  <= in_data[re_hi(DBITS):re_lo(DBITS)];
            s1_ai  <= in_data[im_hi(DBITS):im_lo(DBITS)];
            s1_br  <= coeff_in[re_hi(NBITS):re_lo(NBITS)];
            s1_bi  <= coeff_in[im_hi(NBITS):im_lo(NBITS)];
            s1_idx <= frame_cnt;
        end
        if (s1_valid) begin
            s2_rr  <= PW'(s1_ar) * PW'(s1_br);
            s2_ii  <= PW'(s1_ai) * PW'(s1_bi);
            s2_ri  <= PW'(s1_ar) * PW'(s1_bi);
            s2_ir  <= PW'(s1_ai) * PW'(s1_br);
            s2_idx <= s1_idx;
        end
        if (s2_valid) begin
            s3_re  <= SW'(s2_rr) - SW'(s2_ii);
            s3_im  <= SW'(s2_ri) + SW'(s2_ir);
            s3_idx <= s2_idx;
        end
    end

    twiddle_cmult_sat_round #(
        .IW (SW),
        .OW (DBITS),
        .SH (SH),
        .RND(RND)
    ) u_re_round (
        .value    (s3_re),
        .rounded_c(re_rounded_c),
        .clipped_c(re_clipped_c)
    );

    twiddle_cmult_sat_round #(
        .IW (SW),
        .OW (DBITS),
        .SH (SH),
        .RND(RND)
    ) u_im_round (
        .value    (s3_im),
        .rounded_c(im_rounded_c),
        .clipped_c(im_clipped_c)
    );

endmodule

// File: tb/tb_twiddle_cmult.sv
// Self-checking bench for twiddle_cmult: behavioural model with a 3-deep
// delay line, per-cycle compare on the falling edge, directed and random stimulus.
module tb_twiddle_cmult;

    localparam int NBITS = 2;
    localparam int DBITS = 8;
    localparam int N     = 8;
    localparam int IDXW  = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [2*DBITS-1:0]   in_data;
    logic [2*NBITS-1:0]   coeff_in;
    logic                 out_valid;
    logic [2*DBITS-1:0]   out_data;
    logic [IDXW-1:0]      out_idx;
    logic                 out_last;
    logic                 out_sat;

    twiddle_cmult #(.NBITS(NBITS), .DBITS(DBITS), .N(N), .IDXW(IDXW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .coeff_in (coeff_in),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           v;
        logic [15:0]  d;
        bit           s;
        int           idx;
    } ent_t;

    ent_t        pipe [3];
    int          cnt;
    bit          e_valid;
    logic [15:0] e_data;
    int          e_idx;
    bit          e_last;
    bit          e_sat;
    bit          checking = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Clamp to signed DBITS, reporting whether clipping happened.
    function automatic int clamp(int x, output bit c);
        int hi;
        int lo;
        hi = (1 << (DBITS - 1)) - 1;
        lo = -(1 << (DBITS - 1));
        c = 1'b1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        c = 1'b0;
        return x;
    endfunction

    // Reference complex product in plain integer arithmetic.
    function automatic void calc(int ar, int ai, int br, int bi,
                                 output logic [15:0] d, output bit s);
        int re;
        int im;
        int rnd;
        int qr;
        int qi;
        bit c1;
        bit c2;
        rnd = (NBITS >= 2) ? (1 << (NBITS - 2)) : 0;
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        qr = clamp((re + rnd) >>> (NBITS - 1), c1);
        qi = clamp((im + rnd) >>> (NBITS - 1), c2);
        d = {8'(qr), 8'(qi)};
        s = c1 | c2;
    endfunction

    // Advance the model by one rising edge given the inputs seen at that edge.
    task automatic model_edge(bit r, bit v, int ar, int ai, int br, int bi);
        if (r) begin
            for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
            cnt = 0;
            e_valid = 1'b0;
            e_data = '0;
            e_idx = 0;
            e_last = 1'b0;
            e_sat = 1'b0;
            checking = 1'b1;
        end else begin
            e_valid = pipe[2].v;
            if (pipe[2].v) begin
                e_data = pipe[2].d;
                e_sat  = pipe[2].s;
                e_idx  = pipe[2].idx;
                e_last = (pipe[2].idx == N - 1);
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0].v = v;
            if (v) begin
                calc(ar, ai, br, bi, pipe[0].d, pipe[0].s);
                pipe[0].idx = cnt;
                cnt = (cnt + 1) % N;
            end
        end
    endtask

    task automatic step(bit r, bit v, int ar, int ai, int br, int bi);
        rst      = r;
        in_valid = v;
        in_data  = {8'(ar), 8'(ai)};
        coeff_in = {2'(br), 2'(bi)};
        @(posedge clk);
        model_edge(r, v, ar, ai, br, bi);
        @(negedge clk);
    endtask

    function automatic int rd();
        return int'($urandom_range(255)) - 128;
    endfunction

    function automatic int rc();
        return int'($urandom_range(3)) - 2;
    endfunction

    task automatic rnd_step(bit r, bit v);
        step(r, v, rd(), rd(), rc(), rc());
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            chk("out_data", 32'(out_data), 32'(e_data));
            chk("out_idx", 32'(out_idx), 32'(e_idx));
            chk("out_last", 32'(out_last), 32'(e_last));
            chk("out_sat", 32'(out_sat), 32'(e_sat));
        end
    end

    initial begin
        logic [15:0] pd;
        bit          ps;

        // Pin the model with hand-computed results.
        calc(100, -20, 1, 0, pd, ps);
        chk("model_v1_data", 32'(pd), 32'h32F6);
        chk("model_v1_sat", 32'(ps), 32'd0);
        calc(127, 127, -2, -2, pd, ps);
        chk("model_v2_data", 32'(pd), 32'h0080);
        chk("model_v2_sat", 32'(ps), 32'd1);
        calc(-128, -128, -2, 0, pd, ps);
        chk("model_v3_data", 32'(pd), 32'h7F7F);
        chk("model_v3_sat", 32'(ps), 32'd1);

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Directed vectors with literal DUT expectations three cycles later.
        step(0, 1, 100, -20, 1, 0);
        repeat (3) rnd_step(0, 0);
        chk("v1_valid", 32'(out_valid), 32'd1);
        chk("v1_data", 32'(out_data), 32'h32F6);
        chk("v1_idx", 32'(out_idx), 32'd0);
        chk("v1_sat", 32'(out_sat), 32'd0);

        step(0, 1, 127, 127, -2, -2);
        repeat (3) rnd_step(0, 0);
        chk("v2_data", 32'(out_data), 32'h0080);
        chk("v2_idx", 32'(out_idx), 32'd1);
        chk("v2_sat", 32'(out_sat), 32'd1);

        step(0, 1, -128, -128, -2, 0);
        repeat (3) rnd_step(0, 0);
        chk("v3_data", 32'(out_data), 32'h7F7F);
        chk("v3_sat", 32'(out_sat), 32'd1);

        // Frame wrap with back-to-back valids.
        rnd_step(1, 0);
        repeat (10) rnd_step(0, 1);
        repeat (2) rnd_step(0, 0);
        chk("wrap_last_idx", 32'(out_idx), 32'd0);
        rnd_step(0, 0);
        chk("wrap_final_idx", 32'(out_idx), 32'd1);
        chk("wrap_final_last", 32'(out_last), 32'd0);
        repeat (2) rnd_step(0, 0);

        // Alternating valid/bubble.
        for (int i = 0; i < 12; i++) rnd_step(0, (i % 2) == 0);
        repeat (4) rnd_step(0, 0);

        // Reset with samples in flight.
        rnd_step(0, 1);
        rnd_step(0, 1);
        rnd_step(1, 0);
        repeat (5) rnd_step(0, 0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_data", 32'(out_data), 32'd0);
        step(0, 1, 10, 20, 1, 1);
        repeat (3) rnd_step(0, 0);
        chk("post_rst_idx", 32'(out_idx), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            rnd_step($urandom_range(99) == 0, $urandom_range(9) < 7);
        end
        repeat (4) rnd_step(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
